// File: rtl/alu0_iq_pkg.sv
// Shared types and widths for the ALU0 issue queue.
//   PR_W / ROB_W : physical-register tag and ROB ID widths
//   OP_W / IMM_W : opcode and immediate widths
//   N_WK         : wakeup tag sources (wb0, wb1, ALU0 self broadcast)
//   alu0_iq_entry_t : one queue slot (valid, payload, per-source ready bits)
package alu0_iq_pkg;

  localparam int PR_W  = 6;
  localparam int ROB_W = 6;
  localparam int OP_W  = 5;
  localparam int IMM_W = 20;
  localparam int N_WK  = 3;

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic [IMM_W-1:0] imm;
    logic [PR_W-1:0]  dest;
    logic [PR_W-1:0]  src1;
    logic             src1_rdy;
    logic [PR_W-1:0]  src2;
    logic             src2_rdy;
    logic [ROB_W-1:0] rob_id;
  } alu0_iq_entry_t;

  function automatic logic entry_ready(alu0_iq_entry_t e);
    return e.valid & e.src1_rdy & e.src2_rdy;
  endfunction

endpackage

// File: rtl/alu0_iq_entry.sv
// One issue-queue slot with its wakeup comparators.
// Ports:
//   clk, rst          : clock, async active-high reset
//   flush             : clears the slot on the next edge
//   ld_disp           : load disp_entry (new dispatch)
//   ld_shift          : load shift_entry (compaction from the slot above)
//   disp_entry        : dispatched uop, ready bits from the dispatch stage
//   shift_entry       : contents of the next-higher slot
//   wk_vld, wk_tag    : wakeup broadcasts active this cycle
//   entry_q           : registered slot contents
module alu0_iq_entry
  import alu0_iq_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       ld_disp,
  input  logic                       ld_shift,
  input  alu0_iq_entry_t             disp_entry,
  input  alu0_iq_entry_t             shift_entry,
  input  logic [N_WK-1:0]            wk_vld,
  input  logic [N_WK-1:0][PR_W-1:0]  wk_tag,
  output alu0_iq_entry_t             entry_q
);

  alu0_iq_entry_t entry_d;

  // Wakeups are applied after the hold/shift/dispatch mux, so a uop being
  // shifted down or freshly written still sees this cycle's broadcasts.
  always_comb begin
    entry_d = entry_q;
    if (ld_disp)
      entry_d = disp_entry;
    else if (ld_shift)
      entry_d = shift_entry;

    for (int w = 0; w < N_WK; w++) begin
      if (wk_vld[w] && entry_d.valid) begin
        if (entry_d.src1 == wk_tag[w]) entry_d.src1_rdy = 1'b1;
        if (entry_d.src2 == wk_tag[w]) entry_d.src2_rdy = 1'b1;
      end
    end

    if (flush)
      entry_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) entry_q <= '0;
    else     entry_q <= entry_d;
  end

endmodule

// File: rtl/alu0_issue_queue.sv
// Compacting issue queue for the ALU0 pipe. Oldest uop lives at index 0;
// each cycle the lowest-index ready uop is driven on ALU0_select_* and
// removed, with younger entries shifting down one slot.
// Optional macro: ALU0_IQ_SELF_WAKEUP_EN -- when defined, the issuing uop's
// destination tag is broadcast as a third wakeup source in the same cycle.
// Ports:
//   clk, rst, flush            : clock, async reset, ROB flush
//   disp_*                     : dispatch handshake and uop payload
//   wb0_*/wb1_*                : external wakeup broadcasts
//   ALU0_select_*              : issued uop to register-read
//   iq_count                   : occupied entries
// Tag and ROB widths come from alu0_iq_pkg.
module alu0_issue_queue
  import alu0_iq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         disp_vld,
  output logic                         disp_rdy,
  input  logic [OP_W-1:0]              disp_op,
  input  logic [IMM_W-1:0]             disp_imm,
  input  logic [PR_W-1:0]              disp_dest,
  input  logic [PR_W-1:0]              disp_src1,
  input  logic                         disp_src1_rdy,
  input  logic [PR_W-1:0]              disp_src2,
  input  logic                         disp_src2_rdy,
  input  logic [ROB_W-1:0]             disp_ROB_ID,
  input  logic                         wb0_vld,
  input  logic [PR_W-1:0]              wb0_PR,
  input  logic                         wb1_vld,
  input  logic [PR_W-1:0]              wb1_PR,
  output logic                         ALU0_select_vld,
  output logic [OP_W-1:0]              ALU0_select_op,
  output logic [IMM_W-1:0]             ALU0_select_imm,
  output logic [PR_W-1:0]              ALU0_select_dest,
  output logic [PR_W-1:0]              ALU0_select_source1,
  output logic [PR_W-1:0]              ALU0_select_source2,
  output logic [ROB_W-1:0]             ALU0_select_ROB_ID,
  output logic [$clog2(DEPTH):0]       iq_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  alu0_iq_entry_t             ent_q [DEPTH];
  alu0_iq_entry_t             disp_entry;
  alu0_iq_entry_t             sel_entry;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [CNT_W-1:0]           wr_idx;
  logic [IDX_W-1:0]           sel_idx;
  logic                       sel_found;
  logic                       issue;
  logic                       fire;
  logic [N_WK-1:0]            wk_vld;
  logic [N_WK-1:0][PR_W-1:0]  wk_tag;

  // Oldest-ready select: scanning downward leaves the lowest index standing.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (entry_ready(ent_q[i])) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign sel_entry = ent_q[sel_idx];
  assign issue     = sel_found & ~flush;

  // Full queue refuses dispatch even when a slot frees this cycle.
  assign disp_rdy  = (count_q != CNT_W'(DEPTH));
  assign fire      = disp_vld & disp_rdy & ~flush;
  assign wr_idx    = count_q - CNT_W'(issue);

  always_comb begin
    disp_entry          = '0;
    disp_entry.valid    = 1'b1;
    disp_entry.op       = disp_op;
    disp_entry.imm      = disp_imm;
    disp_entry.dest     = disp_dest;
    disp_entry.src1     = disp_src1;
    disp_entry.src1_rdy = disp_src1_rdy;
    disp_entry.src2     = disp_src2;
    disp_entry.src2_rdy = disp_src2_rdy;
    disp_entry.rob_id   = disp_ROB_ID;
  end

  assign wk_tag = {sel_entry.dest, wb1_PR, wb0_PR};
`ifdef ALU0_IQ_SELF_WAKEUP_EN
  assign wk_vld = {issue, wb1_vld, wb0_vld};
`else
  assign wk_vld = {1'b0, wb1_vld, wb0_vld};
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    alu0_iq_entry_t shift_in;
    if (i == DEPTH - 1) begin : g_top
      assign shift_in = '0;
    end else begin : g_mid
      assign shift_in = ent_q[i+1];
    end

    alu0_iq_entry u_entry (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .ld_disp     (fire && (CNT_W'(i) == wr_idx)),
      .ld_shift    (issue && (IDX_W'(i) >= sel_idx)),
      .disp_entry  (disp_entry),
      .shift_entry (shift_in),
      .wk_vld      (wk_vld),
      .wk_tag      (wk_tag),
      .entry_q     (ent_q[i])
    );
  end

  always_comb begin
    count_d = count_q + CNT_W'(fire) - CNT_W'(issue);
    if (flush) count_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign iq_count            = count_q;
  assign ALU0_select_vld     = issue;
  assign ALU0_select_op      = sel_entry.op;
  assign ALU0_select_imm     = sel_entry.imm;
  assign ALU0_select_dest    = sel_entry.dest;
  assign ALU0_select_source1 = sel_entry.src1;
  assign ALU0_select_source2 = sel_entry.src2;
  assign ALU0_select_ROB_ID  = sel_entry.rob_id;

endmodule

// File: tb/tb_alu0_issue_queue.sv
module tb_alu0_issue_queue;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        disp_vld, disp_rdy;
  logic [4:0]  disp_op;
  logic [19:0] disp_imm;
  logic [5:0]  disp_dest, disp_src1, disp_src2, disp_ROB_ID;
  logic        disp_src1_rdy, disp_src2_rdy;
  logic        wb0_vld, wb1_vld;
  logic [5:0]  wb0_PR, wb1_PR;
  logic        sel_vld;
  logic [4:0]  sel_op;
  logic [19:0] sel_imm;
  logic [5:0]  sel_dest, sel_s1, sel_s2, sel_rob;
  logic [3:0]  iq_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu0_issue_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_vld(disp_vld), .disp_rdy(disp_rdy),
    .disp_op(disp_op), .disp_imm(disp_imm), .disp_dest(disp_dest),
    .disp_src1(disp_src1), .disp_src1_rdy(disp_src1_rdy),
    .disp_src2(disp_src2), .disp_src2_rdy(disp_src2_rdy),
    .disp_ROB_ID(disp_ROB_ID),
    .wb0_vld(wb0_vld), .wb0_PR(wb0_PR), .wb1_vld(wb1_vld), .wb1_PR(wb1_PR),
    .ALU0_select_vld(sel_vld), .ALU0_select_op(sel_op),
    .ALU0_select_imm(sel_imm), .ALU0_select_dest(sel_dest),
    .ALU0_select_source1(sel_s1), .ALU0_select_source2(sel_s2),
    .ALU0_select_ROB_ID(sel_rob), .iq_count(iq_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks sit mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic disp(input logic [4:0] op, input logic [5:0] dest,
                      input logic [5:0] s1, input logic r1,
                      input logic [5:0] s2, input logic r2,
                      input logic [5:0] rob);
    disp_vld = 1'b1; disp_op = op; disp_imm = {14'h0, rob};
    disp_dest = dest; disp_src1 = s1; disp_src1_rdy = r1;
    disp_src2 = s2; disp_src2_rdy = r2; disp_ROB_ID = rob;
  endtask

  task automatic idle();
    disp_vld = 1'b0; wb0_vld = 1'b0; wb1_vld = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; disp_vld = 1'b0; disp_op = '0; disp_imm = '0;
    disp_dest = '0; disp_src1 = '0; disp_src2 = '0; disp_ROB_ID = '0;
    disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0;
    wb0_vld = 1'b0; wb1_vld = 1'b0; wb0_PR = '0; wb1_PR = '0;

    // Reset state
    #12;
    chk("rst_count", iq_count, 0);
    chk("rst_rdy", disp_rdy, 1);
    chk("rst_vld", sel_vld, 0);
    chk("rst_dest", sel_dest, 0);
    chk("rst_rob", sel_rob, 0);
    rst = 1'b0;
    tick();

    // Single ready uop: dispatch in N, issue in N+1
    disp(5'd3, 6'd10, 6'd1, 1'b1, 6'd2, 1'b1, 6'd5);
    disp_imm = 20'h12345;
    settle();
    chk("t1_vld_n", sel_vld, 0);
    tick(); idle();
    settle();
    chk("t1_vld", sel_vld, 1);
    chk("t1_dest", sel_dest, 10);
    chk("t1_rob", sel_rob, 5);
    chk("t1_op", sel_op, 3);
    chk("t1_imm", sel_imm, 20'h12345);
    chk("t1_src1", sel_s1, 1);
    chk("t1_src2", sel_s2, 2);
    chk("t1_cnt1", iq_count, 1);
    tick();
    settle();
    chk("t1_cnt0", iq_count, 0);
    chk("t1_vld_after", sel_vld, 0);
    tick();

    // Younger ready uop bypasses an older waiting one; wakeup in N -> issue N+1
    disp(5'd1, 6'd11, 6'd7, 1'b0, 6'd2, 1'b1, 6'd1);
    tick();
    disp(5'd2, 6'd13, 6'd1, 1'b1, 6'd2, 1'b1, 6'd2);
    tick(); idle();
    settle();
    chk("t2_cnt", iq_count, 2);
    chk("t2_b_vld", sel_vld, 1);
    chk("t2_b_rob", sel_rob, 2);
    tick();
    wb0_vld = 1'b1; wb0_PR = 6'd7;
    settle();
    chk("t2_a_wait", sel_vld, 0);
    tick(); idle();
    settle();
    chk("t2_a_vld", sel_vld, 1);
    chk("t2_a_rob", sel_rob, 1);
    tick();
    settle();
    chk("t2_cnt0", iq_count, 0);
    tick();

    // Fill to capacity with waiting uops, then wake all and drain in age order
    for (int i = 0; i < 8; i++) begin
      disp(5'd4, 6'(30 + i), 6'd20, 1'b0, 6'd2, 1'b1, 6'(i));
      tick();
    end
    idle();
    settle();
    chk("t3_full_rdy", disp_rdy, 0);
    chk("t3_full_cnt", iq_count, 8);
    chk("t3_none", sel_vld, 0);
    tick();
    wb1_vld = 1'b1; wb1_PR = 6'd20;
    tick(); idle();
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("t3_drain_vld", sel_vld, 1);
      chk("t3_drain_rob", sel_rob, k);
      tick();
    end
    settle();
    chk("t3_cnt0", iq_count, 0);
    tick();

    // Back-to-back dependent via self wakeup (or external writeback without it)
    disp(5'd5, 6'd12, 6'd1, 1'b1, 6'd2, 1'b1, 6'd3);
    tick();
    disp(5'd6, 6'd14, 6'd12, 1'b0, 6'd2, 1'b1, 6'd4);
    settle();
    chk("t4_a_vld", sel_vld, 1);
    chk("t4_a_rob", sel_rob, 3);
    tick(); idle();
    settle();
`ifdef ALU0_IQ_SELF_WAKEUP_EN
    chk("t4_b_b2b_vld", sel_vld, 1);
    chk("t4_b_b2b_rob", sel_rob, 4);
    tick();
`else
    chk("t4_b_wait", sel_vld, 0);
    chk("t4_b_cnt", iq_count, 1);
    tick();
    wb0_vld = 1'b1; wb0_PR = 6'd12;
    tick(); idle();
    settle();
    chk("t4_b_vld", sel_vld, 1);
    chk("t4_b_rob", sel_rob, 4);
    tick();
`endif
    settle();
    chk("t4_cnt0", iq_count, 0);
    tick();

    // Full queue: same-cycle issue and dispatch -> dispatch rejected
    for (int i = 0; i < 8; i++) begin
      disp(5'd7, 6'(40 + i), 6'd21, 1'b0, 6'd2, 1'b1, 6'(i));
      tick();
    end
    idle();
    wb0_vld = 1'b1; wb0_PR = 6'd21;
    tick(); idle();
    disp(5'd8, 6'd50, 6'd1, 1'b1, 6'd2, 1'b1, 6'd9);
    settle();
    chk("t5_rdy", disp_rdy, 0);
    chk("t5_vld", sel_vld, 1);
    chk("t5_rob", sel_rob, 0);
    tick(); idle();
    settle();
    chk("t5_cnt7", iq_count, 7);
    for (int k = 1; k < 8; k++) begin
      chk("t5_drain_rob", sel_rob, k);
      tick();
      settle();
    end
    chk("t5_cnt0", iq_count, 0);
    chk("t5_empty_vld", sel_vld, 0);
    tick();

    // Flush with a ready head and a concurrent dispatch
    for (int i = 0; i < 5; i++) begin
      disp(5'd9, 6'(16 + i), 6'd22, 1'b0, 6'd2, 1'b1, 6'(i));
      tick();
    end
    idle();
    wb0_vld = 1'b1; wb0_PR = 6'd22;
    tick(); idle();
    flush = 1'b1;
    disp(5'd10, 6'd60, 6'd1, 1'b1, 6'd2, 1'b1, 6'd33);
    settle();
    chk("t6_cnt5", iq_count, 5);
    chk("t6_flush_vld", sel_vld, 0);
    tick(); idle();
    settle();
    chk("t6_cnt0", iq_count, 0);
    chk("t6_vld0", sel_vld, 0);
    chk("t6_rdy", disp_rdy, 1);
    tick();
    settle();
    chk("t6_still_empty", sel_vld, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu0_issue_queue.md
Name: alu0_issue_queue

Overview:
- Issue queue feeding the ALU0 pipe; sits directly upstream of the ALU0 register-read stage.
- Buffers dispatched ALU0 micro-ops and tracks source-operand readiness from physical-register wakeup broadcasts.
- Each cycle, selects the oldest ready entry and drives the ALU0_select_* bus consumed by register-read.
- Compacting queue: the oldest entry is always at index 0.

Parameters:
DEPTH, 8, number of queue entries (power of two, 4..16)
PR_W, 6, physical-register tag width
ROB_W, 6, ROB ID width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
flush  in  1  pipeline flush from ROB; clears the queue
disp_vld  in  1  dispatch request
disp_rdy  out  1  queue can accept (count < DEPTH)
disp_op  in  5  ALU opcode
disp_imm  in  20  immediate
disp_dest  in  PR_W  destination PR
disp_src1  in  PR_W  source-1 PR
disp_src1_rdy  in  1  source 1 already available
disp_src2  in  PR_W  source-2 PR
disp_src2_rdy  in  1  source 2 already available
disp_ROB_ID  in  ROB_W  ROB ID
wb0_vld, wb1_vld  in  1 each  external wakeup valid (other pipes)
wb0_PR, wb1_PR  in  PR_W each  woken PR tag
ALU0_select_vld  out  1  issued uop valid
ALU0_select_op  out  5
ALU0_select_imm  out  20
ALU0_select_dest  out  PR_W
ALU0_select_source1  out  PR_W
ALU0_select_source2  out  PR_W
ALU0_select_ROB_ID  out  ROB_W
iq_count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, rst=1): all entry valid, ready and payload bits cleared; iq_count=0; disp_rdy=1; ALU0_select_vld=0; all ALU0_select_* fields 0.
- Dispatch fire = disp_vld & disp_rdy.
  - disp_rdy depends only on the current count, not on a same-cycle select.
  - A full queue rejects dispatch even if an entry issues that cycle.
  - The new entry is written at index (count - issued_this_cycle).
- Readiness at insertion: src_rdy = disp_srcN_rdy OR match on any wakeup source active this cycle (wb0, wb1, and the self broadcast if enabled).
- Wakeup: any valid entry whose srcN equals an active wakeup tag sets its srcN_rdy on the next edge. Ready bits never clear except on entry removal.
- Select (combinational from registered state):
  - Lowest-index entry with both ready bits set and valid.
  - ALU0_select_vld=1 and fields = that entry's payload. If no entry is ready, vld=0 and fields hold entry 0's payload (don't-care).
  - There is no downstream backpressure; a select always issues.
- Removal: the selected entry is removed at the clock edge. Entries above it shift down one index, preserving age order, with their wakeups applied in the same edge.
- Latency:
  - Dispatch in cycle N with both sources ready → earliest select in cycle N+1.
  - Wakeup in cycle N → dependent eligible in cycle N+1.
- Count: iq_count_next = count + fire - issued; simultaneous dispatch+issue leaves count unchanged.
- Flush: on the next edge all valid bits are cleared and count becomes 0. A same-cycle dispatch is discarded. ALU0_select_vld is forced 0 in the flush cycle. flush has priority over everything except rst.
- rst asserted mid-operation: immediate clear, no partial issue.

Optional Feature:
ALU0_IQ_SELF_WAKEUP_EN
- Defined:
  - When ALU0_select_vld=1, ALU0_select_dest is broadcast as a third wakeup tag in the same cycle.
  - A single-cycle dependent can therefore issue in the next cycle (back-to-back); the register-read bypass covers the data.
- Undefined:
  - Only wb0/wb1 wake entries.
  - A dependent of an ALU0 op waits for that op's external writeback broadcast.

Decomposition:
- Package alu0_iq_pkg holds:
  - PR_W, ROB_W, OP_W=5, IMM_W=20;
  - typedef alu0_iq_entry_t {valid, op, imm, dest, src1, src1_rdy, src2, src2_rdy, rob_id}.
- One sub-module, alu0_iq_entry:
  - a single entry register with wakeup comparators (3 tags × 2 sources);
  - a shift-in mux selecting hold, shift from index+1, or dispatch write.
- Top level: find-first-ready priority encoder, count logic, output mux.

Test Plan:
- Reset then dispatch op=3 dest=10 src1=1(rdy) src2=2(rdy) ROB=5 → next cycle ALU0_select_vld=1, dest=10, ROB_ID=5; iq_count returns to 0.
- Dispatch A (src1=7 not ready), then B (all ready) → B issues first; then wb0_vld=1, wb0_PR=7 in cycle N → A issues in cycle N+1.
- Fill 8 entries with src1=20 not ready → disp_rdy=0, iq_count=8; wb1_PR=20 → all issue in age order (ROB 0..7), one per cycle.
- SELF_WAKEUP_EN: A dest=12 ready; B src1=12 not ready → A issues cycle N, B issues cycle N+1. Without the macro, B waits for wb0_PR=12.
- Full queue plus same-cycle issue and dispatch → dispatch rejected (disp_rdy=0) and count drops to 7.
- 5 entries valid, flush=1 with disp_vld=1 → ALU0_select_vld=0 that cycle; next cycle iq_count=0, nothing issues.
